// File: rtl/midi_voice_allocator_if.sv
// Byte input and voice-pool outputs exchanged between the MIDI receiver side
// and the voice allocator.
interface midi_voice_allocator_if #(
  parameter int NUM_VOICES = 4
);
  logic [7:0]              byte_in;
  logic                    byte_valid;
  logic [7*NUM_VOICES-1:0] voice_note;
  logic [7*NUM_VOICES-1:0] voice_vel;
  logic [NUM_VOICES-1:0]   voice_gate;
  logic [NUM_VOICES-1:0]   voice_trig;
  logic                    steal;
  logic [3:0]              active_count;

  modport master (
    output byte_in, byte_valid,
    input  voice_note, voice_vel, voice_gate, voice_trig, steal, active_count
  );

  modport slave (
    input  byte_in, byte_valid,
    output voice_note, voice_vel, voice_gate, voice_trig, steal, active_count
  );
endinterface

// File: rtl/midi_voice_allocator.sv
// MIDI byte-stream parser (running status aware) feeding a free-first,
// oldest-steal voice allocator over NUM_VOICES slots.
//
// state        | meaning
// WAIT_STATUS  | no running status; data bytes are dropped
// DATA1        | expecting first data byte of a note/CC message
// DATA2        | expecting second data byte; completes the message
// SKIP2        | discarding first of two data bytes
// SKIP1        | discarding last data byte of an ignored message
module midi_voice_allocator #(
  parameter int         NUM_VOICES = 4,
  parameter logic [3:0] CHANNEL    = 4'd0,
  parameter bit         OMNI       = 1'b1
) (
  input logic                   clk_100mhz,
  input logic                   reset,
  midi_voice_allocator_if.slave bus
);

  localparam int IW = $clog2(NUM_VOICES);

  localparam logic [2:0] WAIT_STATUS = 3'd0;
  localparam logic [2:0] DATA1       = 3'd1;
  localparam logic [2:0] DATA2       = 3'd2;
  localparam logic [2:0] SKIP1       = 3'd3;
  localparam logic [2:0] SKIP2       = 3'd4;

  localparam logic [1:0] EV_ON  = 2'd0;
  localparam logic [1:0] EV_OFF = 2'd1;
  localparam logic [1:0] EV_ALL = 2'd2;

  logic [2:0] state;
  logic [7:0] running_status;
  logic [6:0] d1;
  logic       evt_valid;
  logic [1:0] evt_kind;
  logic [6:0] evt_note;
  logic [6:0] evt_vel;

  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [7:0]            age_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic                  steal_q;
  logic [3:0]            active_q;

  // Where a message with this status begins consuming data bytes; also where
  // SKIP1 returns to so running status keeps working for ignored messages.
  function automatic logic [2:0] entry_state(input logic [7:0] status);
    logic [2:0] s;
    logic       ch_ok;
    ch_ok = OMNI || (status[3:0] == CHANNEL);
    if (!status[7]) begin
      s = WAIT_STATUS;
    end else begin
      case (status[7:4])
        4'h8, 4'h9, 4'hB: s = ch_ok ? DATA1 : SKIP2;
        4'hC, 4'hD:       s = SKIP1;
        default:          s = SKIP2;
      endcase
    end
    return s;
  endfunction

  function automatic logic [3:0] popcount(input logic [NUM_VOICES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_VOICES; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

  logic is_realtime;
  logic is_system;
  assign is_realtime = (bus.byte_in[7:3] == 5'b11111);
  assign is_system   = (bus.byte_in[7:4] == 4'hF) && !is_realtime;

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state          <= WAIT_STATUS;
      running_status <= 8'h00;
      d1             <= 7'd0;
      evt_valid      <= 1'b0;
      evt_kind       <= EV_ON;
      evt_note       <= 7'd0;
      evt_vel        <= 7'd0;
    end else begin
      evt_valid <= 1'b0;
      if (bus.byte_valid && !is_realtime) begin
        if (is_system) begin
          running_status <= 8'h00;
          state          <= WAIT_STATUS;
        end else if (bus.byte_in[7]) begin
          running_status <= bus.byte_in;
          state          <= entry_state(bus.byte_in);
        end else begin
          case (state)
            DATA1: begin
              d1    <= bus.byte_in[6:0];
              state <= DATA2;
            end
            DATA2: begin
              state    <= DATA1;
              evt_note <= d1;
              evt_vel  <= bus.byte_in[6:0];
              if (running_status[7:4] == 4'h9 && bus.byte_in[6:0] != 7'd0) begin
                evt_valid <= 1'b1;
                evt_kind  <= EV_ON;
              end else if (running_status[7:4] == 4'h9 || running_status[7:4] == 4'h8) begin
                evt_valid <= 1'b1;
                evt_kind  <= EV_OFF;
              end else if (running_status[7:4] == 4'hB && d1 == 7'h7B) begin
                evt_valid <= 1'b1;
                evt_kind  <= EV_ALL;
              end
            end
            SKIP2:   state <= SKIP1;
            SKIP1:   state <= entry_state(running_status);
            default: state <= WAIT_STATUS;
          endcase
        end
      end
    end
  end

  logic          match_hit, free_hit, do_steal;
  logic [IW-1:0] match_idx, free_idx, old_idx, target;
  logic [7:0]    old_age;
  logic [NUM_VOICES-1:0] gate_nxt;

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    old_idx   = '0;
    old_age   = age_q[0];
    // Descending scan so the lowest matching index wins.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_q[i] && note_q[i] == evt_note) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
      if (!gate_q[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IW'(i);
      end
    end
    target   = match_hit ? match_idx : (free_hit ? free_idx : old_idx);
    do_steal = !match_hit && !free_hit;

    gate_nxt = gate_q;
    if (evt_valid) begin
      case (evt_kind)
        EV_ON:  gate_nxt[target] = 1'b1;
        EV_OFF: begin
          for (int i = 0; i < NUM_VOICES; i++)
            if (note_q[i] == evt_note) gate_nxt[i] = 1'b0;
        end
        EV_ALL:  gate_nxt = '0;
        default: gate_nxt = gate_q;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= 7'h7F;
        vel_q[i]  <= 7'd0;
        age_q[i]  <= 8'd0;
      end
      gate_q   <= '0;
      trig_q   <= '0;
      steal_q  <= 1'b0;
      active_q <= 4'd0;
    end else begin
      trig_q   <= '0;
      steal_q  <= 1'b0;
      gate_q   <= gate_nxt;
      active_q <= popcount(gate_nxt);
      if (evt_valid && evt_kind == EV_ON) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IW'(i) == target) begin
            note_q[i] <= evt_note;
            vel_q[i]  <= evt_vel;
            age_q[i]  <= 8'd0;
          end else if (age_q[i] != 8'hFF) begin
            age_q[i] <= age_q[i] + 8'd1;
          end
        end
        trig_q[target] <= 1'b1;
        steal_q        <= do_steal;
      end
    end
  end

  logic [7*NUM_VOICES-1:0] note_flat, vel_flat;

  always_comb begin
    note_flat = '0;
    vel_flat  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      note_flat[7*i +: 7] = note_q[i];
      vel_flat[7*i +: 7]  = vel_q[i];
    end
  end

  assign bus.voice_note   = note_flat;
  assign bus.voice_vel    = vel_flat;
  assign bus.voice_gate   = gate_q;
  assign bus.voice_trig   = trig_q;
  assign bus.steal        = steal_q;
  assign bus.active_count = active_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: vector table, corner-case sequences and a
// randomized message stream checked against an event-level voice-pool model.
`timescale 1ns/1ps
module tb_midi_voice_allocator;
  localparam int NV = 4;

  logic clk_100mhz = 1'b0;
  logic reset = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  midi_voice_allocator_if #(.NUM_VOICES(NV)) bus_a();
  midi_voice_allocator_if #(.NUM_VOICES(NV)) bus_b();

  midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(4'd0), .OMNI(1'b1)) dut_a (
    .clk_100mhz(clk_100mhz), .reset(reset), .bus(bus_a));
  midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(4'd1), .OMNI(1'b0)) dut_b (
    .clk_100mhz(clk_100mhz), .reset(reset), .bus(bus_b));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] bytes;
    int          n;
    logic [3:0]  gate;
    logic [3:0]  trig;
    logic        stl;
    logic [3:0]  cnt;
  } vec_t;
  vec_t tbl [13];

  // Voice-pool model: age is derived from allocation timestamps.
  int   m_note [NV];
  int   m_vel  [NV];
  int   m_stamp[NV];
  bit   m_gate [NV];
  int   alloc_n;
  logic [3:0] e_trig;
  logic       e_steal;

  logic [7:0] tb_rs, st, d1, d2;
  int kind, nd, ch, ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 127; m_vel[i] = 0; m_stamp[i] = 0; m_gate[i] = 0;
    end
    alloc_n = 0; e_trig = '0; e_steal = 1'b0;
  endfunction

  function automatic int age_of(int i);
    return (alloc_n - m_stamp[i] > 255) ? 255 : alloc_n - m_stamp[i];
  endfunction

  // ev: 0 none, 1 note on, 2 note off, 3 all off
  function automatic void model_event(int e, int n, int v);
    int tgt, best;
    e_trig = '0; e_steal = 1'b0; tgt = -1;
    if (e == 1) begin
      for (int i = 0; i < NV; i++) if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
      for (int i = 0; i < NV; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
      if (tgt < 0) begin
        best = -1;
        for (int i = 0; i < NV; i++) if (age_of(i) > best) begin best = age_of(i); tgt = i; end
        e_steal = 1'b1;
      end
      alloc_n++;
      m_stamp[tgt] = alloc_n; m_note[tgt] = n; m_vel[tgt] = v; m_gate[tgt] = 1;
      e_trig[tgt] = 1'b1;
    end else if (e == 2) begin
      for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == n) m_gate[i] = 0;
    end else if (e == 3) begin
      for (int i = 0; i < NV; i++) m_gate[i] = 0;
    end
  endfunction

  task automatic check_model(input string tag);
    logic [7*NV-1:0] en, evl;
    logic [NV-1:0]   eg;
    logic [3:0]      ec;
    ec = 4'd0;
    for (int i = 0; i < NV; i++) begin
      en[7*i +: 7] = 7'(m_note[i]);
      evl[7*i +: 7] = 7'(m_vel[i]);
      eg[i] = m_gate[i];
      ec = ec + 4'(m_gate[i]);
    end
    chk({tag, " gate"}, 64'(bus_a.voice_gate), 64'(eg));
    chk({tag, " note"}, 64'(bus_a.voice_note), 64'(en));
    chk({tag, " vel"}, 64'(bus_a.voice_vel), 64'(evl));
    chk({tag, " trig"}, 64'(bus_a.voice_trig), 64'(e_trig));
    chk({tag, " steal"}, 64'(bus_a.steal), 64'(e_steal));
    chk({tag, " count"}, 64'(bus_a.active_count), 64'(ec));
  endtask

  task automatic drive(input bit use_b, input logic [7:0] b);
    @(negedge clk_100mhz);
    if (use_b) begin bus_b.byte_in = b; bus_b.byte_valid = 1'b1; end
    else begin bus_a.byte_in = b; bus_a.byte_valid = 1'b1; end
  endtask

  task automatic idle();
    @(negedge clk_100mhz);
    bus_a.byte_valid = 1'b0;
    bus_b.byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_100mhz);
    reset = 1'b1; bus_a.byte_valid = 1'b0; bus_b.byte_valid = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    reset = 1'b0;
  endtask

  task automatic send_rand(input logic [7:0] b);
    if ($urandom_range(0, 7) == 0) drive(1'b0, 8'hF8);
    drive(1'b0, b);
  endtask

  initial begin
    bus_a.byte_in = 8'h00; bus_a.byte_valid = 1'b0;
    bus_b.byte_in = 8'h00; bus_b.byte_valid = 1'b0;

    tbl[0]  = '{24'h903C64, 3, 4'b0001, 4'b0001, 1'b0, 4'd1};
    tbl[1]  = '{24'h3E5000, 2, 4'b0011, 4'b0010, 1'b0, 4'd2};
    tbl[2]  = '{24'h3C0000, 2, 4'b0010, 4'b0000, 1'b0, 4'd1};
    tbl[3]  = '{24'h803E10, 3, 4'b0000, 4'b0000, 1'b0, 4'd0};
    tbl[4]  = '{24'h90407F, 3, 4'b0001, 4'b0001, 1'b0, 4'd1};
    tbl[5]  = '{24'h417F00, 2, 4'b0011, 4'b0010, 1'b0, 4'd2};
    tbl[6]  = '{24'h427F00, 2, 4'b0111, 4'b0100, 1'b0, 4'd3};
    tbl[7]  = '{24'h437F00, 2, 4'b1111, 4'b1000, 1'b0, 4'd4};
    tbl[8]  = '{24'h447F00, 2, 4'b1111, 4'b0001, 1'b1, 4'd4};
    tbl[9]  = '{24'h457F00, 2, 4'b1111, 4'b0010, 1'b1, 4'd4};
    tbl[10] = '{24'h434000, 2, 4'b1111, 4'b1000, 1'b0, 4'd4};
    tbl[11] = '{24'hB0077F, 3, 4'b1111, 4'b0000, 1'b0, 4'd4};
    tbl[12] = '{24'h7B0000, 2, 4'b0000, 4'b0000, 1'b0, 4'd0};

    do_reset();
    chk("reset note", 64'(bus_a.voice_note), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F}));
    chk("reset vel", 64'(bus_a.voice_vel), 64'd0);
    chk("reset gate", 64'(bus_a.voice_gate), 64'd0);
    chk("reset trig", 64'(bus_a.voice_trig), 64'd0);
    chk("reset steal", 64'(bus_a.steal), 64'd0);
    chk("reset count", 64'(bus_a.active_count), 64'd0);

    for (int r = 0; r < 13; r++) begin
      for (int k = 0; k < tbl[r].n; k++) drive(1'b0, tbl[r].bytes[23-8*k -: 8]);
      idle();
      @(negedge clk_100mhz);
      chk($sformatf("vec%0d gate", r), 64'(bus_a.voice_gate), 64'(tbl[r].gate));
      chk($sformatf("vec%0d trig", r), 64'(bus_a.voice_trig), 64'(tbl[r].trig));
      chk($sformatf("vec%0d steal", r), 64'(bus_a.steal), 64'(tbl[r].stl));
      chk($sformatf("vec%0d count", r), 64'(bus_a.active_count), 64'(tbl[r].cnt));
    end

    // Real-time byte inside a message, and latency of the outputs.
    do_reset();
    drive(1'b0, 8'h90); drive(1'b0, 8'h3C); drive(1'b0, 8'hF8); drive(1'b0, 8'h64);
    idle();
    chk("rt C+1 gate", 64'(bus_a.voice_gate), 64'd0);
    @(negedge clk_100mhz);
    chk("rt gate", 64'(bus_a.voice_gate), 64'b0001);
    chk("rt note0", 64'(bus_a.voice_note[6:0]), 64'h3C);
    chk("rt vel0", 64'(bus_a.voice_vel[6:0]), 64'h64);
    chk("rt trig", 64'(bus_a.voice_trig), 64'b0001);
    @(negedge clk_100mhz);
    chk("rt trig drop", 64'(bus_a.voice_trig), 64'd0);

    // System byte aborts the message and clears running status.
    drive(1'b0, 8'h90); drive(1'b0, 8'h3C); drive(1'b0, 8'hF0); drive(1'b0, 8'h64);
    idle(); @(negedge clk_100mhz);
    chk("sys trig", 64'(bus_a.voice_trig), 64'd0);
    chk("sys gate", 64'(bus_a.voice_gate), 64'b0001);
    drive(1'b0, 8'h3D); drive(1'b0, 8'h40);
    idle(); @(negedge clk_100mhz);
    chk("norun gate", 64'(bus_a.voice_gate), 64'b0001);
    chk("norun trig", 64'(bus_a.voice_trig), 64'd0);
    chk("norun note", 64'(bus_a.voice_note), 64'({7'h7F, 7'h7F, 7'h7F, 7'h3C}));

    // Channel filter and reset mid-message on the single-channel instance.
    do_reset();
    drive(1'b1, 8'h90); drive(1'b1, 8'h3C); drive(1'b1, 8'h64);
    idle(); @(negedge clk_100mhz);
    chk("ch0 gate", 64'(bus_b.voice_gate), 64'd0);
    chk("ch0 trig", 64'(bus_b.voice_trig), 64'd0);
    drive(1'b1, 8'h91); drive(1'b1, 8'h3C); drive(1'b1, 8'h64);
    idle(); @(negedge clk_100mhz);
    chk("ch1 gate", 64'(bus_b.voice_gate), 64'b0001);
    chk("ch1 note0", 64'(bus_b.voice_note[6:0]), 64'h3C);
    drive(1'b1, 8'h91); drive(1'b1, 8'h3C);
    @(negedge clk_100mhz);
    reset = 1'b1; bus_b.byte_valid = 1'b0;
    @(negedge clk_100mhz);
    reset = 1'b0;
    drive(1'b1, 8'h64);
    idle(); @(negedge clk_100mhz);
    chk("mrst gate", 64'(bus_b.voice_gate), 64'd0);
    chk("mrst trig", 64'(bus_b.voice_trig), 64'd0);
    chk("mrst note", 64'(bus_b.voice_note), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F}));
    chk("mrst vel", 64'(bus_b.voice_vel), 64'd0);
    chk("mrst count", 64'(bus_b.active_count), 64'd0);
    chk("mrst steal", 64'(bus_b.steal), 64'd0);

    // Randomized message stream on the omni instance.
    do_reset();
    model_reset();
    tb_rs = 8'h00;
    for (int m = 0; m < 300; m++) begin
      kind = $urandom_range(0, 99);
      ch   = $urandom_range(0, 15);
      d1   = 8'(8'h30 + $urandom_range(0, 7));
      d2   = 8'($urandom_range(1, 127));
      nd   = 2;
      ev   = 0;
      if (kind < 50) begin
        st = 8'h90 | 8'(ch); ev = 1;
      end else if (kind < 80) begin
        ev = 2;
        if ($urandom_range(0, 1) == 1) begin st = 8'h80 | 8'(ch); d2 = 8'($urandom_range(0, 127)); end
        else begin st = 8'h90 | 8'(ch); d2 = 8'h00; end
      end else if (kind < 85) begin
        st = 8'hB0 | 8'(ch); d1 = 8'h7B; ev = 3;
      end else if (kind < 90) begin
        st = 8'hB0 | 8'(ch); d1 = 8'($urandom_range(0, 122));
      end else if (kind < 95) begin
        st = (($urandom_range(0, 1) == 1) ? 8'hC0 : 8'hD0) | 8'(ch); nd = 1;
      end else begin
        st = (($urandom_range(0, 1) == 1) ? 8'hA0 : 8'hE0) | 8'(ch);
      end
      if ($urandom_range(0, 19) == 0) begin
        drive(1'b0, 8'hF7); tb_rs = 8'h00;
      end
      if (st != tb_rs || $urandom_range(0, 1) == 0) begin
        send_rand(st); tb_rs = st;
      end
      send_rand(d1);
      if (nd == 2) send_rand(d2);
      idle();
      @(negedge clk_100mhz);
      model_event(ev, int'(d1), int'(d2));
      check_model($sformatf("rnd%0d", m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Polyphonic MIDI front end that sits between the UART byte receiver and the per-voice sound/display datapath. It parses the received MIDI byte stream, including running status, and extracts Note On, Note Off and All Notes Off events. It then schedules each note onto one of NUM_VOICES shared voice slots using free-first, oldest-steal arbitration. It replaces single-note tracking with a bounded voice pool whose slots downstream generators consume directly.

## Interface
Parameters:
- NUM_VOICES, 4: number of voice slots, 2..8.
- CHANNEL, 4'd0: MIDI channel accepted when OMNI=0.
- OMNI, 1: 1 = accept all channels; 0 = accept only CHANNEL.

Ports:
- clk_100mhz  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk_100mhz.
- byte_in  in  8  received UART byte; valid only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
- voice_note  out  7*NUM_VOICES  note of voice i at [7i+6:7i].
- voice_vel  out  7*NUM_VOICES  velocity of voice i.
- voice_gate  out  NUM_VOICES  1 = voice i currently sounding.
- voice_trig  out  NUM_VOICES  one-cycle pulse when voice i is (re)allocated.
- steal  out  1  one-cycle pulse when an allocation evicts a gated voice.
- active_count  out  4  number of gate bits set.

## Operation
Parser:
- States: WAIT_STATUS, DATA1, DATA2, SKIP1, SKIP2.
- Running status register: running_status (8 bits), cleared to 0.
- Bytes 0xF8–0xFF (real-time) are ignored entirely. State and running status are unchanged.
- Bytes 0xF0–0xF7 clear running status. Next state is WAIT_STATUS, where data bytes are dropped.
- Any other status byte loads running status.
  - 0x8n, 0x9n, 0xBn go to DATA1.
  - 0xCn, 0xDn go to SKIP1.
  - 0xAn, 0xEn go to SKIP2.
- Channel mismatch (OMNI=0): the message is treated like SKIP2. 0xCn/0xDn still use SKIP1.
- DATA1 latches the data byte as d1 and goes to DATA2.
- DATA2 completes a message and returns to DATA1 (running status).
- SKIP2 goes to SKIP1; SKIP1 returns to its entry state for the next data byte.
- A status byte received mid-message aborts the partial message.
- Completed messages:
  - 0x9n with vel>0: NOTE_ON(d1, vel).
  - 0x9n with vel=0, or 0x8n: NOTE_OFF(d1).
  - 0xBn with d1=0x7B: ALL_OFF.
  - Other CC values are ignored.

Allocator (acts on the registered event):
- NOTE_ON allocation target, in priority order:
  - (a) A gated voice whose note equals d1: retrigger.
  - (b) Else the lowest-index voice with gate=0.
  - (c) Else the gated voice with the largest age, ties to the lowest index; steal=1.
- On allocation, the target gets note=d1, vel=vel, gate=1, age=0, and voice_trig[target]=1.
- Every other voice's age increments, saturating at 255.
- NOTE_OFF clears gate on the voice gated with that note. Note and vel are retained. No voice matching means no effect.
- ALL_OFF clears all gates. No trig is issued.
- active_count is the popcount of voice_gate, registered.

## Timing
- Pipeline, with C = the cycle in which the completing byte has byte_valid=1:
  - Event register valid at C+1.
  - voice_* outputs, voice_trig, steal and active_count updated at C+2.
- Events are at most one per two cycles, so no structural hazard arises. An event always sees the allocator state left by the previous event.
- voice_trig and steal are high for exactly one cycle.
- Reset values:
  - voice_note = 7'h7F for all voices; voice_vel = 0; voice_gate = 0; voice_trig = 0; steal = 0; active_count = 0.
  - All ages = 0; running status = 0; parser in WAIT_STATUS; event register empty.
- Reset mid-message discards the partial message and any in-flight event.

## Test plan
- 90 3C 64 -> at C+2: voice_gate=0001, voice_note[0]=0x3C, voice_vel[0]=0x64, voice_trig[0] pulse, active_count=1.
- 90 3C 64 then 3E 50 then 3C 00 (running status) -> voice0=3C and voice1=3E gated; then voice0 gate=0, voice1 gate=1, active_count=1.
- NUM_VOICES=4: note-ons 40,41,42,43,44 -> 44 steals voice0 (oldest), steal pulse. Next note-on 45 steals voice1.
- 90 3C, then F8 in the middle of the message, then 64 -> note-on still completes. 90 3C then F0 then 64 -> no event; running status cleared, so the following 3D 40 is ignored.
- Voices gated, then B0 7B 00 -> all gates 0 at C+2, no trig, active_count=0. B0 07 7F -> no change.
- OMNI=0, CHANNEL=1: 90 3C 64 -> no change; 91 3C 64 -> voice0 gated. Reset asserted after 91 3C, then 64 -> no event, all outputs at reset values.
